// File: rtl/lemon_core_units.sv
// LemonPC datapath leaf units: 64-bit ALU, ADDI/EBREAK decoder with sticky halt,
// and a byte-addressed little-endian memory with a fetch port and a data port.

// Maps one byte lane of an access onto the memory array and flags out-of-range bytes.
module lemon_byte_lane #(
  parameter int                XLEN      = 64,
  parameter logic [XLEN-1:0]   MEM_BASE  = 64'h0000_0000_8000_0000,
  parameter int                MEM_BYTES = 65536,
  parameter int                LANE      = 0,
  parameter int                AW        = $clog2(MEM_BYTES)
) (
  input  logic [XLEN-1:0] addr,
  output logic [AW-1:0]   idx,
  output logic            ok
);
  logic [XLEN-1:0] off;
  // Unsigned wrap makes addresses below MEM_BASE land far above MEM_BYTES.
  assign off = addr - MEM_BASE + XLEN'(LANE);
  assign ok  = off < XLEN'(MEM_BYTES);
  assign idx = off[AW-1:0];
endmodule

module lemon_core_units #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] MEM_BASE  = 64'h0000_0000_8000_0000,
  parameter int              MEM_BYTES = 65536
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [3:0]      alu_sel,
  output logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] inst_addr,
  output logic [31:0]     inst,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic            mem_wen,
  input  logic [7:0]      mem_wmask,
  output logic [XLEN-1:0] mem_rdata,
  output logic [4:0]      rs1,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            rf_wen,
  output logic            is_ebreak,
  output logic            halted
);
  localparam int NUM_LANES = 8;
  localparam int IF_LANES  = 4;
  localparam int AW        = $clog2(MEM_BYTES);

  // ---------------- ALU ----------------
  logic [5:0] shamt;
  assign shamt = alu_b[5:0];

  always_comb begin
    alu_res = '0;
    case (alu_sel)
      4'd0: alu_res = alu_a + alu_b;
      4'd1: alu_res = alu_a - alu_b;
      4'd2: alu_res = alu_a & alu_b;
      4'd3: alu_res = alu_a | alu_b;
      4'd4: alu_res = alu_a ^ alu_b;
      4'd5: alu_res = alu_a << shamt;
      4'd6: alu_res = alu_a >> shamt;
      4'd7: alu_res = $signed(alu_a) >>> shamt;
      4'd8: alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      4'd9: alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      default: alu_res = '0;
    endcase
  end

  // ---------------- memory ----------------
  logic [7:0] mem [MEM_BYTES];

  logic [NUM_LANES-1:0][AW-1:0] d_idx;
  logic [NUM_LANES-1:0]         d_ok;
  logic [NUM_LANES-1:0][7:0]    d_byte;
  logic [IF_LANES-1:0][AW-1:0]  i_idx;
  logic [IF_LANES-1:0]          i_ok;
  logic [IF_LANES-1:0][7:0]     i_byte;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_dlane
    lemon_byte_lane #(.XLEN(XLEN), .MEM_BASE(MEM_BASE), .MEM_BYTES(MEM_BYTES), .LANE(g), .AW(AW))
      u_lane (.addr(mem_addr), .idx(d_idx[g]), .ok(d_ok[g]));
    assign d_byte[g] = d_ok[g] ? mem[d_idx[g]] : 8'h00;
  end

  for (genvar g = 0; g < IF_LANES; g++) begin : g_ilane
    lemon_byte_lane #(.XLEN(XLEN), .MEM_BASE(MEM_BASE), .MEM_BYTES(MEM_BYTES), .LANE(g), .AW(AW))
      u_lane (.addr(inst_addr), .idx(i_idx[g]), .ok(i_ok[g]));
    assign i_byte[g] = i_ok[g] ? mem[i_idx[g]] : 8'h00;
  end

  assign mem_rdata = d_byte;
  assign inst      = i_byte;

  // Writes share the data-port lane mapping; rst and halt deliberately do not gate them.
  always_ff @(posedge clk) begin
    if (mem_wen) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (mem_wmask[i] && d_ok[i]) mem[d_idx[i]] <= mem_wdata[8*i +: 8];
    end
  end

  // ---------------- decode / halt ----------------
  logic is_addi;
  assign rs1       = inst[19:15];
  assign rd        = inst[11:7];
  assign imm       = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign is_addi   = (inst[6:0] == 7'b0010011) && (inst[14:12] == 3'b000);
  assign is_ebreak = (inst == 32'h0010_0073);
  assign rf_wen    = is_addi && !halted;

  always_ff @(posedge clk) begin
    if (rst)            halted <= 1'b0;
    else if (is_ebreak) halted <= 1'b1;
  end
endmodule

// File: tb/tb_lemon_core_units.sv
// Directed self-checking bench for lemon_core_units: ALU ops, memory ports, decode and halt.
module tb_lemon_core_units;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          BYTES = 65536;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_sel;
  logic [63:0] inst_addr, mem_addr, mem_wdata, mem_rdata, imm;
  logic [31:0] inst;
  logic        mem_wen, rf_wen, is_ebreak, halted;
  logic [7:0]  mem_wmask;
  logic [4:0]  rs1, rd;

  int nchk = 0;
  int nfail = 0;

  lemon_core_units #(.XLEN(64), .MEM_BASE(BASE), .MEM_BYTES(BYTES)) dut (
    .clk(clk), .rst(rst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
    .inst_addr(inst_addr), .inst(inst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .rs1(rs1), .rd(rd), .imm(imm), .rf_wen(rf_wen),
    .is_ebreak(is_ebreak), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic alu(input logic [63:0] a, input logic [63:0] b, input logic [3:0] sel,
                     input logic [63:0] exp, input string tag);
    alu_a = a; alu_b = b; alu_sel = sel;
    #1 chk(tag, alu_res, exp);
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] mask);
    mem_addr = addr; mem_wdata = data; mem_wmask = mask; mem_wen = 1'b1;
    @(posedge clk); #1;
    mem_wen = 1'b0;
  endtask

  task automatic rdchk(input logic [63:0] addr, input logic [63:0] exp, input string tag);
    mem_addr = addr;
    #1 chk(tag, mem_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; alu_a = '0; alu_b = '0; alu_sel = '0;
    inst_addr = '0; mem_addr = '0; mem_wdata = '0; mem_wen = 1'b0; mem_wmask = '0;
    @(posedge clk); #1;
    chk("reset_halted", {63'b0, halted}, 64'd0);
    rst = 1'b0;

    // ALU
    alu(64'd5, -64'sd3, 4'd0, 64'd2, "alu_add");
    alu(64'd5, -64'sd3, 4'd1, 64'd8, "alu_sub");
    alu(64'd5, -64'sd3, 4'd8, 64'd0, "alu_slt");
    alu(64'd5, -64'sd3, 4'd9, 64'd1, "alu_sltu");
    alu(64'hF0F0, 64'h0FF0, 4'd2, 64'h00F0, "alu_and");
    alu(64'hF0F0, 64'h0FF0, 4'd3, 64'hFFF0, "alu_or");
    alu(64'hF0F0, 64'h0FF0, 4'd4, 64'hFF00, "alu_xor");
    alu(64'h8000_0000_0000_0000, 64'd4, 4'd7, 64'hF800_0000_0000_0000, "alu_sra");
    alu(64'h8000_0000_0000_0000, 64'd4, 4'd6, 64'h0800_0000_0000_0000, "alu_srl");
    alu(64'd1, 64'd65, 4'd5, 64'd2, "alu_sll_b65");
    alu(-64'sd1, 64'd1, 4'd0, 64'd0, "alu_add_wrap");
    alu(64'd7, 64'd3, 4'd12, 64'd0, "alu_sel12");

    // memory
    wr(BASE, 64'h1122_3344_5566_7788, 8'hFF);
    wr(BASE + 64'd8, 64'hAABB_CCDD_EEFF_0011, 8'h0F);
    rdchk(BASE + 64'd4, 64'hEEFF_0011_1122_3344, "rd_unaligned");
    inst_addr = BASE;
    #1 chk("inst_fetch", {32'b0, inst}, {32'b0, 32'h5566_7788});
    rdchk(BASE - 64'd1, 64'h2233_4455_6677_8800, "rd_below_base");
    rdchk(BASE + 64'(BYTES), 64'd0, "rd_above_top");
    wr(BASE + 64'(BYTES) - 64'd4, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    rdchk(BASE + 64'(BYTES) - 64'd4, 64'h0000_0000_CAFE_F00D, "wr_top_clip");
    wr(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    rdchk(BASE, 64'h1122_3344_5566_7788, "wr_mask0");

    // decode: addi x1,x0,-1 at +0x10, ebreak at +0x14
    wr(BASE + 64'h10, {32'h0010_0073, 32'hFFF0_0093}, 8'hFF);
    inst_addr = BASE + 64'h10;
    #1;
    chk("dec_rs1", {59'b0, rs1}, 64'd0);
    chk("dec_rd", {59'b0, rd}, 64'd1);
    chk("dec_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dec_rfwen", {63'b0, rf_wen}, 64'd1);
    chk("dec_ebreak0", {63'b0, is_ebreak}, 64'd0);

    // halt
    inst_addr = BASE + 64'h14;
    #1;
    chk("ebreak_comb", {63'b0, is_ebreak}, 64'd1);
    chk("halt_pre_edge", {63'b0, halted}, 64'd0);
    @(posedge clk); #1;
    chk("halt_set", {63'b0, halted}, 64'd1);
    inst_addr = BASE + 64'h10;
    @(posedge clk); #1;
    chk("halt_sticky", {63'b0, halted}, 64'd1);
    chk("halt_rfwen", {63'b0, rf_wen}, 64'd0);

    // read-during-write on both ports, while halted
    inst_addr = BASE;
    mem_addr = BASE; mem_wdata = 64'h0102_0304_0506_0708; mem_wmask = 8'h0F; mem_wen = 1'b1;
    #1;
    chk("rdw_old_data", mem_rdata, 64'h1122_3344_5566_7788);
    chk("rdw_old_inst", {32'b0, inst}, {32'b0, 32'h5566_7788});
    @(posedge clk); #1;
    mem_wen = 1'b0;
    chk("rdw_new_data", mem_rdata, 64'h1122_3344_0506_0708);
    chk("rdw_new_inst", {32'b0, inst}, {32'b0, 32'h0506_0708});

    // reset beats ebreak
    inst_addr = BASE + 64'h14;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_over_ebreak", {63'b0, halted}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("halt_reset_again", {63'b0, halted}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
